uop_queue: RTL and testbench

- Micro-op buffer sitting directly downstream of the decode unit.
- Accepts a decoded group of 1–3 20-bit uops in a single cycle via the feed_req/feed_ack handshake.
- Issues the uops one per cycle, in program order, to the execute stage using a valid/ready handshake.
- Marks the final uop of each instruction; supports a single-cycle flush on redirect.

---
 rtl/uop_queue.sv | 90 +++++++++
 tb/tb_uop_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uop_queue.sv
// rtl/uop_queue.sv - micro-op buffer between decode and execute
// Accepts 1-3 uop groups per cycle and issues one uop per cycle in program order.
module uop_queue #(
  parameter int DEPTH = 8,
  parameter int UOP_W = 20
) (
  input  logic                       clk,
  input  logic                       a_rst,
  input  logic                       flush,
  output logic                       feed_req,
  input  logic                       feed_ack,
  input  logic [UOP_W-1:0]           uop_0,
  input  logic [UOP_W-1:0]           uop_1,
  input  logic [UOP_W-1:0]           uop_2,
  input  logic [1:0]                 uop_count,
  output logic [UOP_W-1:0]           uop_out,
  output logic                       uop_last,
  output logic                       uop_valid,
  input  logic                       uop_ready,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] MAX_FILL = (PTR_W+1)'(DEPTH - 3);

  logic [UOP_W:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_1;
  logic [PTR_W-1:0] wr_ptr_2;
  logic [1:0]       cnt_eff;
  logic [1:0]       n;
  logic [PTR_W:0]   n_lvl;
  logic             wr_en;
  logic             pop;
  logic [UOP_W:0]   head;

  // A count of 3 is treated as a 3-uop group.
  assign cnt_eff  = (uop_count == 2'd3) ? 2'd2 : uop_count;
  assign n        = cnt_eff + 2'd1;
  assign wr_ptr_1 = wr_ptr + PTR_W'(1);
  assign wr_ptr_2 = wr_ptr + PTR_W'(2);

  assign feed_req  = (level <= MAX_FILL) & ~flush;
  assign wr_en     = feed_ack & feed_req;
  assign uop_valid = (level != '0);
  assign pop       = uop_valid & uop_ready & ~flush;
  assign n_lvl     = wr_en ? (PTR_W+1)'(n) : '0;

  assign head     = mem[rd_ptr];
  assign uop_out  = head[UOP_W-1:0];
  assign uop_last = uop_valid & head[UOP_W];

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(n);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + n_lvl - (PTR_W+1)'(pop);
    end
  end

  // Storage is not reset; only the uop_0 entry carries the last flag.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (cnt_eff)
        2'd2: begin
          mem[wr_ptr]   <= {1'b0, uop_2};
          mem[wr_ptr_1] <= {1'b0, uop_1};
          mem[wr_ptr_2] <= {1'b1, uop_0};
        end
        2'd1: begin
          mem[wr_ptr]   <= {1'b0, uop_1};
          mem[wr_ptr_1] <= {1'b1, uop_0};
        end
        default: begin
          mem[wr_ptr]   <= {1'b1, uop_0};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uop_queue.sv
// tb/tb_uop_queue.sv - directed vector bench for uop_queue
// Each vector checks pre-edge outputs for its inputs, then the clock advances.
module tb_uop_queue;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        flush;
  logic        feed_req;
  logic        feed_ack;
  logic [19:0] uop_0, uop_1, uop_2;
  logic [1:0]  uop_count;
  logic [19:0] uop_out;
  logic        uop_last;
  logic        uop_valid;
  logic        uop_ready;
  logic [3:0]  level;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        ack;
    logic [1:0]  cnt;
    logic [19:0] u2, u1, u0;
    logic        rdy;
    logic        fl;
    logic        e_valid;
    logic [19:0] e_out;
    logic        e_last;
    logic [3:0]  e_level;
    logic        e_req;
  } vec_t;

  vec_t vecs[$];

  uop_queue #(.DEPTH(8), .UOP_W(20)) dut (
    .clk(clk), .a_rst(a_rst), .flush(flush), .feed_req(feed_req),
    .feed_ack(feed_ack), .uop_0(uop_0), .uop_1(uop_1), .uop_2(uop_2),
    .uop_count(uop_count), .uop_out(uop_out), .uop_last(uop_last),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic ack, input logic [1:0] cnt, input logic [19:0] u2, u1, u0,
                     input logic rdy, input logic fl, input logic ev, input logic [19:0] eo,
                     input logic el, input logic [3:0] elv, input logic er);
    vec_t v;
    v.ack = ack; v.cnt = cnt; v.u2 = u2; v.u1 = u1; v.u0 = u0; v.rdy = rdy; v.fl = fl;
    v.e_valid = ev; v.e_out = eo; v.e_last = el; v.e_level = elv; v.e_req = er;
    vecs.push_back(v);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input int idx, input logic ev, input logic [19:0] eo,
                            input logic el, input logic [3:0] elv, input logic er);
    chk("uop_valid", idx, 32'(uop_valid), 32'(ev));
    chk("level", idx, 32'(level), 32'(elv));
    chk("feed_req", idx, 32'(feed_req), 32'(er));
    chk("uop_last", idx, 32'(uop_last), 32'(el));
    if (ev) chk("uop_out", idx, 32'(uop_out), 32'(eo));
  endtask

  initial begin
    a_rst = 1'b0; flush = 1'b0; feed_ack = 1'b0; uop_count = 2'd0;
    uop_0 = '0; uop_1 = '0; uop_2 = '0; uop_ready = 1'b0;

    // basic 3-uop group, issued in order
    add(0,0,0,0,0,          0,0, 0,0,0,0,1);
    add(1,2,'h3,'h2,'h1,    1,0, 0,0,0,0,1);
    add(0,0,0,0,0,          1,0, 1,'h3,0,3,1);
    add(0,0,0,0,0,          1,0, 1,'h2,0,2,1);
    add(0,0,0,0,0,          1,0, 1,'h1,1,1,1);
    add(0,0,0,0,0,          0,0, 0,0,0,0,1);
    // fill to 6 with no reads; extra ack ignored
    add(1,0,0,0,'h10,       0,0, 0,0,0,0,1);
    add(1,2,'h23,'h22,'h21, 0,0, 1,'h10,1,1,1);
    add(1,1,0,'h32,'h31,    0,0, 1,'h10,1,4,1);
    add(1,0,0,0,'h99,       0,0, 1,'h10,1,6,0);
    add(0,0,0,0,0,          0,0, 1,'h10,1,6,0);
    // drain to 2
    add(0,0,0,0,0,          1,0, 1,'h10,1,6,0);
    add(0,0,0,0,0,          1,0, 1,'h23,0,5,1);
    add(0,0,0,0,0,          1,0, 1,'h22,0,4,1);
    add(0,0,0,0,0,          1,0, 1,'h21,1,3,1);
    // write and pop in the same cycle at level 2
    add(1,1,0,'h42,'h41,    1,0, 1,'h32,0,2,1);
    add(0,0,0,0,0,          0,0, 1,'h31,1,3,1);
    add(0,0,0,0,0,          1,0, 1,'h31,1,3,1);
    add(0,0,0,0,0,          1,0, 1,'h42,0,2,1);
    add(0,0,0,0,0,          1,0, 1,'h41,1,1,1);
    add(0,0,0,0,0,          0,0, 0,0,0,0,1);
    // move pointers to 7, then a straddling group in slots 7,0,1
    add(1,2,'h53,'h52,'h51, 1,0, 0,0,0,0,1);
    add(1,0,0,0,'h54,       1,0, 1,'h53,0,3,1);
    add(0,0,0,0,0,          1,0, 1,'h52,0,3,1);
    add(0,0,0,0,0,          1,0, 1,'h51,1,2,1);
    add(0,0,0,0,0,          1,0, 1,'h54,1,1,1);
    add(1,3,'h63,'h62,'h61, 0,0, 0,0,0,0,1);
    add(0,0,0,0,0,          1,0, 1,'h63,0,3,1);
    add(0,0,0,0,0,          1,0, 1,'h62,0,2,1);
    add(0,0,0,0,0,          1,0, 1,'h61,1,1,1);
    add(0,0,0,0,0,          0,0, 0,0,0,0,1);
    // flush at level 5 with a concurrent ack and ready
    add(1,2,'h73,'h72,'h71, 0,0, 0,0,0,0,1);
    add(1,1,0,'h82,'h81,    0,0, 1,'h73,0,3,1);
    add(1,2,'h93,'h92,'h91, 1,1, 1,'h73,0,5,0);
    add(0,0,0,0,0,          0,0, 0,0,0,0,1);
    add(1,0,0,0,'hA1,       0,0, 0,0,0,0,1);
    add(0,0,0,0,0,          0,0, 1,'hA1,1,1,1);

    #1;
    check_outs(-1, 0, 0, 0, 0, 1);
    @(negedge clk);
    a_rst = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      feed_ack = vecs[i].ack; uop_count = vecs[i].cnt;
      uop_2 = vecs[i].u2; uop_1 = vecs[i].u1; uop_0 = vecs[i].u0;
      uop_ready = vecs[i].rdy; flush = vecs[i].fl;
      #2;
      check_outs(i, vecs[i].e_valid, vecs[i].e_out, vecs[i].e_last, vecs[i].e_level, vecs[i].e_req);
      step();
    end

    // asynchronous reset in the middle of a drain
    feed_ack = 1'b1; uop_count = 2'd2; uop_2 = 'hB3; uop_1 = 'hB2; uop_0 = 'hB1;
    uop_ready = 1'b0; flush = 1'b0;
    step();
    feed_ack = 1'b0; uop_ready = 1'b1;
    #2;
    check_outs(100, 1, 'hA1, 1, 4, 1);
    step();
    #2;
    check_outs(101, 1, 'hB3, 0, 3, 1);
    a_rst = 1'b0;
    #1;
    check_outs(102, 0, 0, 0, 0, 1);
    step();
    check_outs(103, 0, 0, 0, 0, 1);
    a_rst = 1'b1;
    uop_ready = 1'b0;
    step();
    check_outs(104, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
